// File: rtl/setup_menu_param.sv
// setup_menu_param
// Keypad-driven editor for N_FIELDS numeric settings. It sits between the
// keypad decoder and the operational controller. Typed decimal digits are
// collected into a BCD entry buffer. The buffer is clamped to the field's
// [MIN,MAX] range when it is applied. '*' moves to the next field, '#'
// commits, and 'C' cancels. An inactivity timeout also aborts the edit.
//
// Ports:
//   clk         clock
//   rst         synchronous active-low reset
//   setup_on    request to enter edit mode (level or pulse)
//   key_value   key code: 0-9 digit, A='*', B='#', C=cancel, D-F ignored
//   key_valid   one-cycle strobe qualifying key_value
//   cfg_out     committed configuration, field i at [i*FIELD_W +: FIELD_W]
//   cfg_ok      one-cycle pulse when a commit completes
//   cfg_abort   one-cycle pulse when an edit is discarded (cancel or timeout)
//   display_en  high while editing
//   disp_field  index of the field being edited
//   disp_bcd    entry buffer if non-empty, else the working field value, in BCD
module setup_menu_param #(
    parameter int N_FIELDS = 4,
    parameter int FIELD_W  = 7,
    parameter int DIGITS   = 2,
    parameter logic [N_FIELDS*FIELD_W-1:0] FIELD_MIN  = {7'd0, 7'd0, 7'd0,  7'd5},
    parameter logic [N_FIELDS*FIELD_W-1:0] FIELD_MAX  = {7'd1, 7'd7, 7'd99, 7'd60},
    parameter logic [N_FIELDS*FIELD_W-1:0] FIELD_INIT = {7'd1, 7'd3, 7'd10, 7'd23},
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          setup_on,
    input  logic [3:0]                    key_value,
    input  logic                          key_valid,
    output logic [N_FIELDS*FIELD_W-1:0]   cfg_out,
    output logic                          cfg_ok,
    output logic                          cfg_abort,
    output logic                          display_en,
    output logic [$clog2(N_FIELDS)-1:0]   disp_field,
    output logic [DIGITS*4-1:0]           disp_bcd
);

    localparam int IDX_W = $clog2(N_FIELDS);
    localparam int BUF_W = DIGITS * 4;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int BIN_W = $clog2(10 ** DIGITS);
    localparam int CMP_W = (BIN_W > FIELD_W) ? BIN_W : FIELD_W;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {IDLE, EDIT} state_t;

    state_t                        state;
    logic [N_FIELDS*FIELD_W-1:0]   work;
    logic [BUF_W-1:0]              entry_buf;
    logic [CNT_W-1:0]              entry_cnt;
    logic [IDX_W-1:0]              idx;
    logic [TMR_W-1:0]              timer;

    logic [FIELD_W-1:0]            cur_field;
    logic [FIELD_W-1:0]            cur_min;
    logic [FIELD_W-1:0]            cur_max;
    logic [FIELD_W-1:0]            applied;
    logic [N_FIELDS*FIELD_W-1:0]   work_applied;
    logic [IDX_W-1:0]              idx_next;

    // Entry buffer (BCD, most significant digit first) to binary.
    function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [BUF_W-1:0] b);
        logic [BIN_W-1:0] v;
        v = '0;
        for (int d = DIGITS - 1; d >= 0; d--)
            v = BIN_W'(v * BIN_W'(10)) + BIN_W'(b[d*4 +: 4]);
        return v;
    endfunction

    // Clamp at the wider of the two widths, so that an out-of-range entry
    // cannot wrap before the comparison. Truncate to the field width last.
    function automatic logic [FIELD_W-1:0] clamp(input logic [BIN_W-1:0] v,
                                                 input logic [FIELD_W-1:0] lo,
                                                 input logic [FIELD_W-1:0] hi);
        logic [CMP_W-1:0] vv, l, h, r;
        vv = CMP_W'(v);
        l  = CMP_W'(lo);
        h  = CMP_W'(hi);
        if (vv < l)      r = l;
        else if (vv > h) r = h;
        else             r = vv;
        return FIELD_W'(r);
    endfunction

    // Field value to DIGITS BCD digits. Only the low digits are kept.
    function automatic logic [BUF_W-1:0] bin_to_bcd(input logic [FIELD_W-1:0] v);
        logic [FIELD_W-1:0] t;
        logic [BUF_W-1:0]   r;
        t = v;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(t % FIELD_W'(10));
            t = t / FIELD_W'(10);
        end
        return r;
    endfunction

    assign cur_field = work[idx*FIELD_W +: FIELD_W];
    assign cur_min   = FIELD_MIN[idx*FIELD_W +: FIELD_W];
    assign cur_max   = FIELD_MAX[idx*FIELD_W +: FIELD_W];
    assign applied   = clamp(bcd_to_bin(entry_buf), cur_min, cur_max);
    assign idx_next  = (idx == IDX_W'(N_FIELDS - 1)) ? '0 : idx + IDX_W'(1);

    // Working copy with any pending entry folded into the current field.
    // Both '*' and '#' use it.
    always_comb begin
        work_applied = work;
        if (entry_cnt != '0)
            work_applied[idx*FIELD_W +: FIELD_W] = applied;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            work      <= FIELD_INIT;
            cfg_out   <= FIELD_INIT;
            entry_buf <= '0;
            entry_cnt <= '0;
            idx       <= '0;
            timer     <= '0;
            cfg_ok    <= 1'b0;
            cfg_abort <= 1'b0;
        end else begin
            cfg_ok    <= 1'b0;
            cfg_abort <= 1'b0;
            case (state)
                IDLE: begin
                    // Any key arriving with setup_on is deliberately lost.
                    if (setup_on) begin
                        state     <= EDIT;
                        work      <= cfg_out;
                        idx       <= '0;
                        entry_buf <= '0;
                        entry_cnt <= '0;
                        timer     <= '0;
                    end
                end
                EDIT: begin
                    if (key_valid) begin
                        timer <= '0;
                        if (key_value <= 4'd9) begin
                            // The new digit becomes the LSD. The oldest digit falls off the top.
                            entry_buf <= (entry_buf << 4) | BUF_W'(key_value);
                            if (entry_cnt != CNT_W'(DIGITS))
                                entry_cnt <= entry_cnt + CNT_W'(1);
                        end else if (key_value == 4'hA) begin
                            work      <= work_applied;
                            idx       <= idx_next;
                            entry_buf <= '0;
                            entry_cnt <= '0;
                        end else if (key_value == 4'hB) begin
                            work      <= work_applied;
                            cfg_out   <= work_applied;
                            cfg_ok    <= 1'b1;
                            state     <= IDLE;
                            entry_buf <= '0;
                            entry_cnt <= '0;
                        end else if (key_value == 4'hC) begin
                            cfg_abort <= 1'b1;
                            state     <= IDLE;
                            entry_buf <= '0;
                            entry_cnt <= '0;
                        end
                    end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        cfg_abort <= 1'b1;
                        state     <= IDLE;
                        entry_buf <= '0;
                        entry_cnt <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign display_en = (state == EDIT);
    assign disp_field = idx;
    assign disp_bcd   = !display_en        ? '0 :
                        (entry_cnt != '0)  ? entry_buf :
                                             bin_to_bcd(cur_field);

endmodule

// File: tb/tb_setup_menu_param.sv
module tb_setup_menu_param;

    logic        clk;
    logic        rst;
    logic        setup_on;
    logic [3:0]  key_value;
    logic        key_valid;
    logic [27:0] cfg_out;
    logic        cfg_ok;
    logic        cfg_abort;
    logic        display_en;
    logic [1:0]  disp_field;
    logic [7:0]  disp_bcd;

    int passed = 0;
    int total  = 0;

    setup_menu_param dut (
        .clk        (clk),
        .rst        (rst),
        .setup_on   (setup_on),
        .key_value  (key_value),
        .key_valid  (key_valid),
        .cfg_out    (cfg_out),
        .cfg_ok     (cfg_ok),
        .cfg_abort  (cfg_abort),
        .display_en (display_en),
        .disp_field (disp_field),
        .disp_bcd   (disp_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [27:0] pack(input int f3, input int f2, input int f1, input int f0);
        return {7'(f3), 7'(f2), 7'(f1), 7'(f0)};
    endfunction

    // Each helper returns at a falling edge, one edge after the capturing rising edge.
    task automatic key(input logic [3:0] k);
        @(negedge clk);
        key_value = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic enter_setup();
        @(negedge clk);
        setup_on = 1'b1;
        @(negedge clk);
        setup_on = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; setup_on = 1'b0; key_value = 4'h0; key_valid = 1'b0;

        // 1. reset
        @(negedge clk); @(negedge clk);
        check("rst_cfg", 32'(cfg_out), 32'(pack(1, 3, 10, 23)));
        check("rst_ok", 32'(cfg_ok), 0);
        check("rst_abort", 32'(cfg_abort), 0);
        check("rst_disp_en", 32'(display_en), 0);
        check("rst_bcd", 32'(disp_bcd), 0);
        check("rst_field", 32'(disp_field), 0);
        rst = 1'b1;

        // 2. digit shifting, '*', commit
        enter_setup();
        check("t2_disp_en", 32'(display_en), 1);
        check("t2_work_bcd", 32'(disp_bcd), 32'h23);
        key(4'h1); key(4'h2);
        check("t2_buf12", 32'(disp_bcd), 32'h12);
        key(4'h3);
        check("t2_buf23", 32'(disp_bcd), 32'h23);
        key(4'hA);
        check("t2_field1", 32'(disp_field), 1);
        check("t2_f1_bcd", 32'(disp_bcd), 32'h10);
        key(4'hB);
        check("t2_ok", 32'(cfg_ok), 1);
        check("t2_cfg", 32'(cfg_out), 32'(pack(1, 3, 10, 23)));
        check("t2_idle", 32'(display_en), 0);
        @(negedge clk);
        check("t2_ok_pulse", 32'(cfg_ok), 0);

        // 3. min and max clamp on field 0
        enter_setup();
        key(4'h0); key(4'h3);
        check("t3_buf03", 32'(disp_bcd), 32'h03);
        key(4'hA); key(4'hB);
        check("t3_min", 32'(cfg_out), 32'(pack(1, 3, 10, 5)));
        enter_setup();
        check("t3_work5", 32'(disp_bcd), 32'h05);
        key(4'h9); key(4'h7); key(4'hA); key(4'hB);
        check("t3_max", 32'(cfg_out), 32'(pack(1, 3, 10, 60)));

        // 4. index wrap with values untouched, then direct commit of a pending entry
        enter_setup();
        key(4'hA);
        check("t4_idx1", 32'(disp_field), 1);
        key(4'hA);
        check("t4_idx2", 32'(disp_field), 2);
        check("t4_f2_bcd", 32'(disp_bcd), 32'h03);
        key(4'hA);
        check("t4_idx3", 32'(disp_field), 3);
        check("t4_f3_bcd", 32'(disp_bcd), 32'h01);
        key(4'hA);
        check("t4_idx0", 32'(disp_field), 0);
        check("t4_f0_bcd", 32'(disp_bcd), 32'h60);
        key(4'h7);
        key(4'hD);
        check("t4_keyD", 32'(disp_bcd), 32'h07);
        key(4'hB);
        check("t4_ok", 32'(cfg_ok), 1);
        check("t4_cfg", 32'(cfg_out), 32'(pack(1, 3, 10, 7)));

        // Field 2 clamps 9 down to its max of 7.
        enter_setup();
        key(4'hA); key(4'hA); key(4'h9); key(4'hB);
        check("t4_f2_clamp", 32'(cfg_out), 32'(pack(1, 7, 10, 7)));

        // 5. cancel, then timeout
        enter_setup();
        key(4'h4); key(4'h0); key(4'hA); key(4'hC);
        check("t5_abort", 32'(cfg_abort), 1);
        check("t5_no_ok", 32'(cfg_ok), 0);
        check("t5_cfg", 32'(cfg_out), 32'(pack(1, 7, 10, 7)));
        check("t5_idle", 32'(display_en), 0);
        @(negedge clk);
        check("t5_abort_pulse", 32'(cfg_abort), 0);
        enter_setup();
        key(4'h4);
        n = 0;
        while (!cfg_abort && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("t5_timeout", 32'(cfg_abort), 1);
        check("t5_timeout_cyc", 32'(n), 1000);
        check("t5_to_idle", 32'(display_en), 0);
        check("t5_to_cfg", 32'(cfg_out), 32'(pack(1, 7, 10, 7)));

        // 6. reset mid-edit, then a key arriving with setup_on
        enter_setup();
        key(4'h5);
        check("t6_buf05", 32'(disp_bcd), 32'h05);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_cfg", 32'(cfg_out), 32'(pack(1, 3, 10, 23)));
        check("t6_rst_idle", 32'(display_en), 0);
        rst = 1'b1;
        @(negedge clk);
        setup_on = 1'b1; key_value = 4'h8; key_valid = 1'b1;
        @(negedge clk);
        setup_on = 1'b0; key_valid = 1'b0;
        check("t6_edit", 32'(display_en), 1);
        check("t6_key_dropped", 32'(disp_bcd), 32'h23);
        key(4'hB);
        check("t6_ok", 32'(cfg_ok), 1);
        check("t6_cfg", 32'(cfg_out), 32'(pack(1, 3, 10, 23)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
